// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store data requesters. One registered access at a time, alternating
// priority under contention, one-cycle acknowledge in a RELEASE state.
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN; without it
// ACCESS waits for iMemRdy indefinitely and oErr is constant 0.
module mem_port_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iF_req,
  input  logic [31:0] iF_addr,
  output logic [31:0] oF_data,
  output logic        oF_ack,
  input  logic        iD_req,
  input  logic        iD_we,
  input  logic [31:0] iD_addr,
  input  logic [31:0] iD_wdata,
  output logic [31:0] oD_data,
  output logic        oD_ack,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic        oBusy,
  output logic        oErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_data_q, grant_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] f_data_q, f_data_d;
  logic        f_ack_q, f_ack_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_ack_q, d_ack_d;
  logic        busy_q, busy_d;
  logic        pick_data;
  logic        finish;
  logic [31:0] ret_data;
  logic        err_d;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q;
`else
  logic        unused_params;
  assign unused_params = ^{TIMEOUT_CYCLES, ERR_DATA, err_d};
`endif

  // Next-state and next-output computation for the arbiter FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_data_d = grant_data_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    f_data_d     = f_data_q;
    f_ack_d      = 1'b0;
    d_data_d     = d_data_q;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    pick_data    = 1'b0;
    finish       = 1'b0;
    ret_data     = iMemData;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (iF_req || iD_req) begin
          // under contention, the requester that did not win last time wins
          pick_data    = iD_req && (!iF_req || !last_grant_q);
          grant_data_d = pick_data;
          last_grant_d = pick_data;
          mem_addr_d   = pick_data ? iD_addr : iF_addr;
          if (pick_data && iD_we) begin
            mem_data_d = iD_wdata;
          end
          mem_read_d   = ~(pick_data & iD_we);
          mem_write_d  = pick_data & iD_we;
          state_d      = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
        end
      end
      ACCESS: begin
        if (iMemRdy) begin
          finish   = 1'b1;
          ret_data = iMemData;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES) begin
          finish   = 1'b1;
          ret_data = ERR_DATA;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
        if (finish) begin
          if (!grant_data_q) begin
            f_data_d = ret_data;
            f_ack_d  = 1'b1;
          end else begin
            if (!mem_write_q) begin
              d_data_d = ret_data;
            end
            d_ack_d = 1'b1;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops strobes and acks at once
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_data_q <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_data_q   <= 32'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      f_data_q     <= 32'd0;
      f_ack_q      <= 1'b0;
      d_data_q     <= 32'd0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_data_q <= grant_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      f_data_q     <= f_data_d;
      f_ack_q      <= f_ack_d;
      d_data_q     <= d_data_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter and error pulse, present only with the timeout feature
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign oErr = err_q;
`else
  assign oErr = 1'b0;
`endif

  assign oF_data   = f_data_q;
  assign oF_ack    = f_ack_q;
  assign oD_data   = d_data_q;
  assign oD_ack    = d_ack_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemData  = mem_data_q;
  assign oMemRead  = mem_read_q;
  assign oMemWrite = mem_write_q;
  assign oBusy     = busy_q;

endmodule
